// File: rtl/agex_stage.sv
// Address-generate/execute stage: ALU, load/store address generation, branch resolution
// with a registered fetch redirect, and an iterative shift-add multiplier that stalls decode.
module agex_stage #(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned INSTBITS  = 32,
  parameter int unsigned REGNOBITS = 5,
  parameter int unsigned MULCYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [INSTBITS-1:0]  in_inst,
  input  logic [DBITS-1:0]     in_pc,
  input  logic [4:0]           in_op,
  input  logic [DBITS-1:0]     in_inst_count,
  input  logic [DBITS-1:0]     in_rs1_val,
  input  logic [DBITS-1:0]     in_rs2_val,
  input  logic [DBITS-1:0]     in_imm,
  input  logic [REGNOBITS-1:0] in_rd,
  input  logic                 in_reg_wr,
  output logic                 stall_to_de,
  output logic                 redirect_valid,
  output logic [DBITS-1:0]     redirect_pc,
  output logic                 out_valid,
  output logic [INSTBITS-1:0]  out_inst,
  output logic [DBITS-1:0]     out_pc,
  output logic [4:0]           out_op,
  output logic [DBITS-1:0]     out_inst_count,
  output logic [DBITS-1:0]     out_regval,
  output logic [DBITS-1:0]     out_memaddr,
  output logic [DBITS-1:0]     out_wr_val,
  output logic                 out_wr_mem,
  output logic                 out_rd_mem,
  output logic [REGNOBITS-1:0] out_rd,
  output logic                 out_reg_wr
);

  localparam int unsigned CNTBITS = $clog2(MULCYCLES);
  localparam int unsigned SHBITS  = $clog2(DBITS);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLT  = 5'd5;
  localparam logic [4:0] OP_SLTU = 5'd6;
  localparam logic [4:0] OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9;
  localparam logic [4:0] OP_LW   = 5'd10;
  localparam logic [4:0] OP_SW   = 5'd11;
  localparam logic [4:0] OP_BEQ  = 5'd12;
  localparam logic [4:0] OP_BNE  = 5'd13;
  localparam logic [4:0] OP_BLT  = 5'd14;
  localparam logic [4:0] OP_BGE  = 5'd15;
  localparam logic [4:0] OP_JAL  = 5'd16;
  localparam logic [4:0] OP_JALR = 5'd17;
  localparam logic [4:0] OP_LUI  = 5'd18;
  localparam logic [4:0] OP_AUIPC= 5'd19;
  localparam logic [4:0] OP_MUL  = 5'd20;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t               state_q, state_d;
  logic [CNTBITS-1:0]   cnt_q, cnt_d;
  logic [DBITS-1:0]     mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [INSTBITS-1:0]  m_inst_q, m_inst_d;
  logic [DBITS-1:0]     m_pc_q, m_pc_d, m_ic_q, m_ic_d;
  logic [REGNOBITS-1:0] m_rd_q, m_rd_d;
  logic                 m_reg_wr_q, m_reg_wr_d;

  logic                 valid_q, valid_d;
  logic [INSTBITS-1:0]  inst_q, inst_d;
  logic [DBITS-1:0]     pc_q, pc_d, ic_q, ic_d;
  logic [4:0]           op_q, op_d;
  logic [DBITS-1:0]     regval_q, regval_d, memaddr_q, memaddr_d, wrval_q, wrval_d;
  logic                 wrmem_q, wrmem_d, rdmem_q, rdmem_d, regwr_q, regwr_d;
  logic [REGNOBITS-1:0] rd_q, rd_d;
  logic                 redir_q, redir_d;
  logic [DBITS-1:0]     rpc_q, rpc_d;

  logic                 accept;
  logic [DBITS-1:0]     alu_res, target, mul_sum;
  logic                 writes, taken;
  logic [SHBITS-1:0]    shamt;

  // A redirect cycle's input is a wrong-path fetch, so it is never accepted.
  assign accept      = in_valid & (state_q == S_IDLE) & ~redir_q;
  assign stall_to_de = (state_q == S_BUSY);
  assign shamt       = in_rs2_val[SHBITS-1:0];
  assign mul_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle result, destination-write qualifier and branch resolution
  always_comb begin
    alu_res = '0;
    writes  = 1'b1;
    taken   = 1'b0;
    target  = in_pc + in_imm;
    case (in_op)
      OP_ADD:   alu_res = in_rs1_val + in_rs2_val;
      OP_SUB:   alu_res = in_rs1_val - in_rs2_val;
      OP_AND:   alu_res = in_rs1_val & in_rs2_val;
      OP_OR:    alu_res = in_rs1_val | in_rs2_val;
      OP_XOR:   alu_res = in_rs1_val ^ in_rs2_val;
      OP_SLT:   alu_res = DBITS'($signed(in_rs1_val) < $signed(in_rs2_val));
      OP_SLTU:  alu_res = DBITS'(in_rs1_val < in_rs2_val);
      OP_SLL:   alu_res = in_rs1_val << shamt;
      OP_SRL:   alu_res = in_rs1_val >> shamt;
      OP_SRA:   alu_res = DBITS'($signed(in_rs1_val) >>> shamt);
      OP_LW:    writes = 1'b1;
      OP_SW:    writes = 1'b0;
      OP_BEQ: begin writes = 1'b0; taken = (in_rs1_val == in_rs2_val); end
      OP_BNE: begin writes = 1'b0; taken = (in_rs1_val != in_rs2_val); end
      OP_BLT: begin writes = 1'b0; taken = ($signed(in_rs1_val) <  $signed(in_rs2_val)); end
      OP_BGE: begin writes = 1'b0; taken = ($signed(in_rs1_val) >= $signed(in_rs2_val)); end
      OP_JAL: begin alu_res = in_pc + DBITS'(4); taken = 1'b1; end
      OP_JALR: begin
        alu_res = in_pc + DBITS'(4);
        taken   = 1'b1;
        target  = (in_rs1_val + in_imm) & ~DBITS'(1);
      end
      OP_LUI:   alu_res = in_imm;
      OP_AUIPC: alu_res = in_pc + in_imm;
      default:  writes = 1'b0;
    endcase
  end

  // Next-state: latch defaults to a bubble every cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    m_inst_d   = m_inst_q;
    m_pc_d     = m_pc_q;
    m_ic_d     = m_ic_q;
    m_rd_d     = m_rd_q;
    m_reg_wr_d = m_reg_wr_q;
    valid_d    = 1'b0;
    inst_d     = '0;
    pc_d       = '0;
    op_d       = '0;
    ic_d       = '0;
    regval_d   = '0;
    memaddr_d  = '0;
    wrval_d    = '0;
    wrmem_d    = 1'b0;
    rdmem_d    = 1'b0;
    rd_d       = '0;
    regwr_d    = 1'b0;
    redir_d    = 1'b0;
    rpc_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_op == OP_MUL) begin
            state_d    = S_BUSY;
            cnt_d      = '0;
            acc_d      = '0;
            mcand_d    = in_rs1_val;
            mplier_d   = in_rs2_val;
            m_inst_d   = in_inst;
            m_pc_d     = in_pc;
            m_ic_d     = in_inst_count;
            m_rd_d     = in_rd;
            m_reg_wr_d = in_reg_wr;
          end else begin
            valid_d   = 1'b1;
            inst_d    = in_inst;
            pc_d      = in_pc;
            op_d      = in_op;
            ic_d      = in_inst_count;
            rd_d      = in_rd;
            regval_d  = alu_res;
            regwr_d   = in_reg_wr & writes;
            if ((in_op == OP_LW) || (in_op == OP_SW)) begin
              memaddr_d = in_rs1_val + in_imm;
            end
            if (in_op == OP_SW) begin
              wrval_d = in_rs2_val;
              wrmem_d = 1'b1;
            end
            rdmem_d = (in_op == OP_LW);
            if (taken) begin
              redir_d = 1'b1;
              rpc_d   = target;
            end
          end
        end
      end
      S_BUSY: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNTBITS'(1);
        if (cnt_q == CNTBITS'(MULCYCLES - 1)) begin
          state_d  = S_IDLE;
          valid_d  = 1'b1;
          inst_d   = m_inst_q;
          pc_d     = m_pc_q;
          op_d     = OP_MUL;
          ic_d     = m_ic_q;
          rd_d     = m_rd_q;
          regval_d = mul_sum;
          regwr_d  = m_reg_wr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      m_inst_q   <= '0;
      m_pc_q     <= '0;
      m_ic_q     <= '0;
      m_rd_q     <= '0;
      m_reg_wr_q <= 1'b0;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
      op_q       <= '0;
      ic_q       <= '0;
      regval_q   <= '0;
      memaddr_q  <= '0;
      wrval_q    <= '0;
      wrmem_q    <= 1'b0;
      rdmem_q    <= 1'b0;
      rd_q       <= '0;
      regwr_q    <= 1'b0;
      redir_q    <= 1'b0;
      rpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      m_inst_q   <= m_inst_d;
      m_pc_q     <= m_pc_d;
      m_ic_q     <= m_ic_d;
      m_rd_q     <= m_rd_d;
      m_reg_wr_q <= m_reg_wr_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      ic_q       <= ic_d;
      regval_q   <= regval_d;
      memaddr_q  <= memaddr_d;
      wrval_q    <= wrval_d;
      wrmem_q    <= wrmem_d;
      rdmem_q    <= rdmem_d;
      rd_q       <= rd_d;
      regwr_q    <= regwr_d;
      redir_q    <= redir_d;
      rpc_q      <= rpc_d;
    end
  end

  assign redirect_valid = redir_q;
  assign redirect_pc    = rpc_q;
  assign out_valid      = valid_q;
  assign out_inst       = inst_q;
  assign out_pc         = pc_q;
  assign out_op         = op_q;
  assign out_inst_count = ic_q;
  assign out_regval     = regval_q;
  assign out_memaddr    = memaddr_q;
  assign out_wr_val     = wrval_q;
  assign out_wr_mem     = wrmem_q;
  assign out_rd_mem     = rdmem_q;
  assign out_rd         = rd_q;
  assign out_reg_wr     = regwr_q;

endmodule

// File: tb/tb_agex_stage.sv
// Bench for agex_stage: directed scenarios plus random traffic against a cycle-level
// behavioural model (plain arithmetic, multiply operator, countdown for MUL latency).
module tb_agex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_inst, in_pc, in_inst_count, in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_op, in_rd;
  logic        in_reg_wr;
  logic        stall_to_de, redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst, out_pc, out_inst_count, out_regval, out_memaddr, out_wr_val;
  logic [4:0]  out_op, out_rd;
  logic        out_wr_mem, out_rd_mem, out_reg_wr;

  int errors = 0;
  int checks = 0;

  // model state
  bit          m_redir;
  int          m_left;
  logic [31:0] m_res, m_inst, m_pc, m_ic;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic [31:0] ic_ctr = 32'd1;

  // expected latch
  logic        e_valid, e_wrmem, e_rdmem, e_regwr, e_redir, e_stall;
  logic [31:0] e_inst, e_pc, e_ic, e_regval, e_memaddr, e_wrval, e_rpc;
  logic [4:0]  e_op, e_rd;

  always #5 clk = ~clk;

  agex_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_op(in_op), .in_inst_count(in_inst_count), .in_rs1_val(in_rs1_val),
    .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd), .in_reg_wr(in_reg_wr),
    .stall_to_de(stall_to_de), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_op(out_op),
    .out_inst_count(out_inst_count), .out_regval(out_regval), .out_memaddr(out_memaddr),
    .out_wr_val(out_wr_val), .out_wr_mem(out_wr_mem), .out_rd_mem(out_rd_mem),
    .out_rd(out_rd), .out_reg_wr(out_reg_wr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit slt_s(input logic [31:0] a, input logic [31:0] b);
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  // Reference semantics of one non-MUL instruction
  task automatic ref_exec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] pc,
                          output logic [31:0] r, output bit wr, output bit tk,
                          output logic [31:0] tgt);
    int s;
    s   = int'(b % 32);
    r   = 32'd0;
    wr  = 1'b1;
    tk  = 1'b0;
    tgt = pc + imm;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = slt_s(a, b) ? 32'd1 : 32'd0;
      5'd6:  r = (a < b) ? 32'd1 : 32'd0;
      5'd7:  r = a << s;
      5'd8:  r = a >> s;
      5'd9:  r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      5'd10: r = 32'd0;
      5'd11: wr = 1'b0;
      5'd12: begin wr = 1'b0; tk = (a == b); end
      5'd13: begin wr = 1'b0; tk = (a != b); end
      5'd14: begin wr = 1'b0; tk = slt_s(a, b); end
      5'd15: begin wr = 1'b0; tk = !slt_s(a, b); end
      5'd16: begin r = pc + 32'd4; tk = 1'b1; end
      5'd17: begin r = pc + 32'd4; tk = 1'b1; tgt = (a + imm) & 32'hFFFF_FFFE; end
      5'd18: r = imm;
      5'd19: r = pc + imm;
      default: wr = 1'b0;
    endcase
  endtask

  // Predict the latch for the coming edge, clock, then compare every output
  task automatic step();
    logic [31:0] r, tgt;
    bit wr, tk;
    e_valid = 0; e_inst = 0; e_pc = 0; e_op = 0; e_ic = 0; e_regval = 0; e_memaddr = 0;
    e_wrval = 0; e_wrmem = 0; e_rdmem = 0; e_rd = 0; e_regwr = 0; e_redir = 0; e_rpc = 0;
    if (reset) begin
      m_left = 0;
      m_redir = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_redir = 0;
      if (m_left == 0) begin
        e_valid = 1; e_inst = m_inst; e_pc = m_pc; e_op = 5'd20; e_ic = m_ic;
        e_rd = m_rd; e_regval = m_res; e_regwr = m_rw;
      end
    end else if (in_valid && !m_redir) begin
      if (in_op == 5'd20) begin
        m_left = 32; m_res = in_rs1_val * in_rs2_val;
        m_inst = in_inst; m_pc = in_pc; m_ic = in_inst_count; m_rd = in_rd; m_rw = in_reg_wr;
        m_redir = 0;
      end else begin
        ref_exec(in_op, in_rs1_val, in_rs2_val, in_imm, in_pc, r, wr, tk, tgt);
        e_valid = 1; e_inst = in_inst; e_pc = in_pc; e_op = in_op; e_ic = in_inst_count;
        e_rd = in_rd; e_regval = r; e_regwr = in_reg_wr & wr;
        e_memaddr = (in_op == 5'd10 || in_op == 5'd11) ? in_rs1_val + in_imm : 32'd0;
        e_wrval = (in_op == 5'd11) ? in_rs2_val : 32'd0;
        e_wrmem = (in_op == 5'd11);
        e_rdmem = (in_op == 5'd10);
        e_redir = tk;
        e_rpc = tk ? tgt : 32'd0;
        m_redir = tk;
      end
    end else begin
      m_redir = 0;
    end
    e_stall = (m_left > 0);
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_inst", out_inst, e_inst);
    chk("out_pc", out_pc, e_pc);
    chk("out_op", 32'(out_op), 32'(e_op));
    chk("out_inst_count", out_inst_count, e_ic);
    chk("out_regval", out_regval, e_regval);
    chk("out_memaddr", out_memaddr, e_memaddr);
    chk("out_wr_val", out_wr_val, e_wrval);
    chk("out_wr_mem", 32'(out_wr_mem), 32'(e_wrmem));
    chk("out_rd_mem", 32'(out_rd_mem), 32'(e_rdmem));
    chk("out_rd", 32'(out_rd), 32'(e_rd));
    chk("out_reg_wr", 32'(out_reg_wr), 32'(e_regwr));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_redir));
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("stall_to_de", 32'(stall_to_de), 32'(e_stall));
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    in_valid      = v;
    in_op         = op;
    in_pc         = pc;
    in_rs1_val    = a;
    in_rs2_val    = b;
    in_imm        = imm;
    in_inst       = $urandom;
    in_inst_count = ic_ctr;
    in_rd         = 5'($urandom_range(1, 31));
    in_reg_wr     = 1'b1;
    ic_ctr        = ic_ctr + 32'd1;
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("reset_stall", 32'(stall_to_de), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);

    drive(1'b1, 5'd0, 32'h10, 32'h7FFF_FFFF, 32'd1, 32'd0);
    step();
    chk("add_ovf_regval", out_regval, 32'h8000_0000);
    chk("add_ovf_valid", 32'(out_valid), 32'd1);
    chk("add_ovf_reg_wr", 32'(out_reg_wr), 32'd1);

    drive(1'b1, 5'd9, 32'h14, 32'h8000_0000, 32'h24, 32'd0);
    step();
    chk("sra_regval", out_regval, 32'hF800_0000);

    drive(1'b1, 5'd11, 32'h18, 32'h100, 32'hDEAD, 32'd8);
    step();
    chk("sw_memaddr", out_memaddr, 32'h108);
    chk("sw_wr_val", out_wr_val, 32'hDEAD);
    chk("sw_wr_mem", 32'(out_wr_mem), 32'd1);
    chk("sw_reg_wr", 32'(out_reg_wr), 32'd0);

    drive(1'b1, 5'd10, 32'h1C, 32'h100, 32'hDEAD, 32'd8);
    step();
    chk("lw_rd_mem", 32'(out_rd_mem), 32'd1);
    chk("lw_memaddr", out_memaddr, 32'h108);

    drive(1'b1, 5'd12, 32'h40, 32'd5, 32'd5, 32'h10);
    step();
    chk("beq_redirect", 32'(redirect_valid), 32'd1);
    chk("beq_target", redirect_pc, 32'h50);
    drive(1'b1, 5'd0, 32'h44, 32'd1, 32'd2, 32'd0);
    step();
    chk("squash_valid", 32'(out_valid), 32'd0);
    chk("squash_redirect", 32'(redirect_valid), 32'd0);

    drive(1'b1, 5'd17, 32'h20, 32'h103, 32'd0, 32'd0);
    step();
    chk("jalr_target", redirect_pc, 32'h102);
    chk("jalr_link", out_regval, 32'h24);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();

    drive(1'b1, 5'd20, 32'h60, 32'hFFFF_FFFF, 32'd3, 32'd0);
    step();
    chk("mul_accept_stall", 32'(stall_to_de), 32'd1);
    drive(1'b1, 5'd0, 32'h64, 32'd7, 32'd8, 32'd0);
    for (int i = 1; i < 32; i++) begin
      step();
      chk("mul_busy_stall", 32'(stall_to_de), 32'd1);
      chk("mul_busy_bubble", 32'(out_valid), 32'd0);
    end
    step();
    chk("mul_result", out_regval, 32'hFFFF_FFFD);
    chk("mul_valid", 32'(out_valid), 32'd1);
    chk("mul_done_stall", 32'(stall_to_de), 32'd0);
    step();
    chk("held_add_regval", out_regval, 32'd15);
    chk("held_add_valid", 32'(out_valid), 32'd1);

    drive(1'b1, 5'd20, 32'h70, 32'd1234, 32'd5678, 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mul_abort_stall", 32'(stall_to_de), 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("mul_abort_no_result", 32'(out_valid), 32'd0);
    end

    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom & 32'hFFFF_FFFC,
            a, ($urandom_range(0, 3) == 0) ? a : $urandom,
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom);
      in_reg_wr = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/agex_stage.md
Name: agex_stage

Overview:
- Address-generate/execute stage, directly upstream of the memory stage; consumes the decode latch and produces the AGEX latch that the memory stage reads.
- Performs ALU ops, load/store address and store-data generation, and branch/jump resolution with a registered redirect to fetch.
- Executes MUL in an iterative 32-cycle shift-add unit and stalls decode while it is busy.

Parameters:
- DBITS, 32, data/address width.
- INSTBITS, 32, instruction width.
- REGNOBITS, 5, register index width.
- MULCYCLES, 32, MUL iterations; must equal DBITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode latch holds a live instruction
- in_inst  in  INSTBITS  raw instruction
- in_pc  in  DBITS  instruction PC
- in_op  in  5  op code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 LW, 11 SW, 12 BEQ, 13 BNE, 14 BLT, 15 BGE, 16 JAL, 17 JALR, 18 LUI, 19 AUIPC, 20 MUL; others are NOP
- in_inst_count  in  DBITS  retire tag, passed through
- in_rs1_val / in_rs2_val  in  DBITS  source operands, already forwarded
- in_imm  in  DBITS  sign-extended immediate; for I-type ALU forms decode places it in in_rs2_val
- in_rd  in  REGNOBITS  destination register
- in_reg_wr  in  1  instruction writes rd
- stall_to_de  out  1  decode must hold its latch
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  DBITS  redirect target
- out_valid, out_inst, out_pc, out_op, out_inst_count  out  (as inputs)  registered AGEX latch fields
- out_regval  out  DBITS  ALU/MUL/link result
- out_memaddr  out  DBITS  rs1+imm for LW/SW, else 0
- out_wr_val  out  DBITS  store data (rs2)
- out_wr_mem  out  1  valid SW
- out_rd_mem  out  1  valid LW
- out_rd  out  REGNOBITS
- out_reg_wr  out  1  in_reg_wr & valid

Behaviour:
- Reset:
  - All out_* = 0, redirect_valid = 0, redirect_pc = 0, stall_to_de = 0.
  - State IDLE, MUL counter 0.
  - Reset mid-MUL aborts the MUL with no result.
- Accept condition: accept = in_valid & (state==IDLE) & !redirect_valid.
  - Cycles without accept load a bubble into the latch: out_valid=0 and all write/enable fields 0.
- Single-cycle ops: latency 1; the result appears in the latch on the edge after accept.
- Arithmetic:
  - 32-bit wraparound.
  - Shifts use operand2[4:0].
  - SLT/BLT/BGE are signed; SLTU is unsigned.
  - LUI result = imm; AUIPC = pc+imm.
  - JAL/JALR write pc+4.
- Branches/jumps:
  - Taken-branch target = pc+imm; JAL target = pc+imm; JALR target = (rs1+imm) & ~1.
  - On accept of a taken branch or jump: redirect_valid=1 and redirect_pc=target are registered alongside the latch for exactly one cycle.
  - In that redirect cycle the presented input is a wrong-path instruction and is squashed (not accepted).
  - A not-taken branch produces no redirect and writes nothing.
- Memory ops: out_memaddr = rs1+imm; out_wr_val = rs2. SW sets out_wr_mem=1 and out_reg_wr=0; LW sets out_rd_mem=1.
- MUL state machine (IDLE, BUSY):
  - IDLE -> BUSY on accept of MUL: capture multiplicand, multiplier, and all pass-through fields; clear accumulator; counter=0. The latch gets a bubble.
  - BUSY, each cycle: if multiplier[0], add multiplicand to accumulator; shift multiplicand left 1 and multiplier right 1; counter++.
  - When counter==MULCYCLES-1: return to IDLE and load the latch with valid=1, regval = low 32 bits of the product.
  - The result is in the latch 32 edges after the accept edge.
  - stall_to_de = (state==BUSY), combinational. Input is ignored while BUSY. Decode re-presents the held instruction, which is accepted on the first IDLE cycle.
- Pass-through: inst, pc, op, inst_count, rd are copied unmodified for valid instructions.

Test Plan:
- Reset held 2 cycles, then released with in_valid=0 -> all outputs 0; stall_to_de=0.
- ADD rs1=0x7FFFFFFF, rs2=1 -> next cycle out_valid=1, out_regval=0x80000000, out_reg_wr=1. SRA 0x80000000 by 0x24 -> out_regval=0xF8000000.
- SW rs1=0x100, imm=8, rs2=0xDEAD -> out_memaddr=0x108, out_wr_val=0xDEAD, out_wr_mem=1, out_reg_wr=0. LW with the same operands -> out_rd_mem=1.
- BEQ pc=0x40, imm=0x10, equal operands, followed by an ADD presented in the next cycle:
  - redirect_valid=1, redirect_pc=0x50 for one cycle.
  - The ADD is squashed: the latch holds a bubble that cycle.
- JALR pc=0x20, rs1=0x103, imm=0 -> redirect_pc=0x102, out_regval=0x24.
- MUL 0xFFFFFFFF x 3, then ADD held behind it:
  - stall_to_de high for 32 cycles; the latch holds bubbles.
  - After the 32nd busy edge: out_regval=0xFFFFFFFD, out_valid=1.
  - The ADD is accepted the next cycle.
  - A second MUL with reset asserted at busy cycle 10 -> IDLE, stall_to_de=0, no result ever appears.
